// File: rtl/mux_sel_pkg.sv
// Shared types and helpers for the 4-channel mux select arbiter.
package mux_sel_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [N_CH-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [N_CH-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_pick
  import mux_sel_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] pick
);

  logic [N_CH-1:0]  w_rot;
  logic [SEL_W-1:0] w_off;

  // Rotate so ptr lands at bit 0, priority-encode, then add ptr back.
  always_comb begin
    w_rot = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_rot[k] = req[SEL_W'(ptr + SEL_W'(k))];
    end
    w_off = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (w_rot[k] && !found) begin
        found = 1'b1;
        w_off = SEL_W'(k);
      end
    end
    pick = ptr + w_off;
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin burst arbiter driving the select pair of a 4:1 bit mux.
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  gnt,
  output logic             sel_valid,
  output logic             beat
);

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [N_CH-1:0]  r_gnt;
  logic             r_sel_valid;
  logic             w_found;
  logic [SEL_W-1:0] w_pick;

  rr_pick u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .pick  (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_sel_nxt   = w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Release takes precedence over a beat in the same cycle.
        if (!req[r_sel]) begin
          w_state_nxt = ST_GAP;
        end else if (out_ready) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(BURST_LEN - 1)) begin
            w_state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        w_ptr_nxt   = r_sel + SEL_W'(1);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_sel_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sel       <= w_sel_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sel_valid <= (w_state_nxt == ST_GRANT);
      r_gnt       <= (w_state_nxt == ST_GRANT) ? sel_onehot(w_sel_nxt) : '0;
    end
  end

  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign sel_valid = r_sel_valid;
  assign beat      = r_sel_valid & out_ready;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed and random checks of mux_sel_arbiter against a cycle reference model.
module tb_mux_sel_arbiter;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       out_ready = 1'b0;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       sel_valid;
  logic       beat;

  mux_sel_arbiter #(.BURST_LEN(BL), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .sel_valid (sel_valid),
    .beat      (beat)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase 0 = waiting, 1 = granted, 2 = turnaround.
  int m_st  = 0;
  int m_ptr = 0;
  int m_sel = 0;
  int m_cnt = 0;

  logic       obs_valid;
  logic       obs_beat;
  logic [1:0] obs_sel;
  logic [3:0] obs_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] r, input logic o, input logic rs);
    if (rs) begin
      m_st = 0; m_ptr = 0; m_sel = 0; m_cnt = 0;
    end else begin
      case (m_st)
        0: begin
          for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (r[c]) begin
              m_sel = c; m_cnt = 0; m_st = 1;
              break;
            end
          end
        end
        1: begin
          if (!r[m_sel]) m_st = 2;
          else if (o) begin
            m_cnt++;
            if (m_cnt == BL) m_st = 2;
          end
        end
        default: begin
          m_ptr = (m_sel + 1) % 4;
          m_st  = 0;
        end
      endcase
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic o, input logic rs);
    req = r; out_ready = o; rst = rs;
    #1;
    obs_valid = sel_valid; obs_beat = beat; obs_sel = sel; obs_gnt = gnt;
    chk("sel_valid", sel_valid, (m_st == 1));
    chk("sel", sel, m_sel);
    chk("gnt", gnt, (m_st == 1) ? (1 << m_sel) : 0);
    chk("beat", beat, (m_st == 1) && o);
    @(posedge clk);
    model_edge(r, o, rs);
    #1;
  endtask

  task automatic do_reset();
    cyc(4'b1111, 1'b1, 1'b1);
    cyc(4'b1111, 1'b1, 1'b1);
  endtask

  initial begin
    int         gq[$];
    int         bq[$];
    int         exp_ord[5];
    logic       prev;
    int         n_gv;
    logic [3:0] rr;
    logic       ro;
    logic       rrs;

    exp_ord = '{0, 1, 2, 3, 0};
    @(posedge clk);
    model_edge(4'b0000, 1'b0, 1'b1);
    #1;

    // Reset then round-robin fairness with all channels requesting
    do_reset();
    prev = 1'b0;
    for (int i = 0; i < 60 && gq.size() < 6; i++) begin
      cyc(4'b1111, 1'b1, 1'b0);
      if (i == 0) chk("post_rst_idle", obs_valid, 1'b0);
      if (i == 1) begin
        chk("post_rst_sel", obs_sel, 2'd0);
        chk("post_rst_gnt", obs_gnt, 4'b0001);
      end
      if (obs_valid && !prev) begin
        gq.push_back(int'(obs_sel));
        bq.push_back(0);
      end
      if (obs_valid && obs_beat) bq[$] = bq[$] + 1;
      prev = obs_valid;
    end
    chk("rr_grants_seen", (gq.size() >= 5), 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k < gq.size()) begin
        chk("rr_order", gq[k], exp_ord[k]);
        chk("rr_beats", bq[k], BL);
      end
    end

    // Full burst on channel 2: valid x4, gap, idle, re-grant
    do_reset();
    begin
      logic [7:0] pat;
      pat = 8'b1001_1110;
      for (int i = 0; i < 8; i++) begin
        cyc(4'b0100, 1'b1, 1'b0);
        chk("burst_valid_pattern", obs_valid, pat[i]);
        if (obs_valid) chk("burst_sel", obs_sel, 2'd2);
      end
    end

    // Backpressure for 3 cycles once two beats are in
    do_reset();
    cyc(4'b0100, 1'b1, 1'b0);
    n_gv = 0;
    for (int i = 0; i < 20; i++) begin
      ro = (i >= 2 && i < 5) ? 1'b0 : 1'b1;
      cyc(4'b0100, ro, 1'b0);
      if (!obs_valid) break;
      n_gv++;
      chk("bp_sel", obs_sel, 2'd2);
    end
    chk("bp_grant_cycles", n_gv, BL + 3);

    // Early release of channel 1 after two beats
    do_reset();
    cyc(4'b0010, 1'b1, 1'b0);
    cyc(4'b0010, 1'b1, 1'b0);
    chk("er_sel", obs_sel, 2'd1);
    cyc(4'b0010, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    chk("er_release_valid", obs_valid, 1'b1);
    cyc(4'b1001, 1'b1, 1'b0);
    chk("er_gap", obs_valid, 1'b0);
    cyc(4'b1001, 1'b1, 1'b0);
    chk("er_idle", obs_valid, 1'b0);
    cyc(4'b1001, 1'b1, 1'b0);
    chk("er_next_valid", obs_valid, 1'b1);
    chk("er_next_sel", obs_sel, 2'd3);

    // Reset mid-burst at cnt == 3
    do_reset();
    cyc(4'b1111, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b1);
    chk("mr_valid_before", obs_valid, 1'b1);
    cyc(4'b1010, 1'b1, 1'b0);
    chk("mr_abort", obs_valid, 1'b0);
    cyc(4'b1010, 1'b1, 1'b0);
    chk("mr_regrant_valid", obs_valid, 1'b1);
    chk("mr_regrant_sel", obs_sel, 2'd1);

    // Random traffic with sticky requests, backpressure and rare resets
    rr = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
      ro  = ($urandom_range(0, 3) != 0);
      rrs = ($urandom_range(0, 99) == 0);
      cyc(rr, ro, rrs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Round-robin arbiter that sits directly upstream of the 4:1 gate-level bit mux and drives its select pair. Four channels request the shared 1-bit output path. The block grants one channel at a time for a bounded burst and presents a registered 2-bit select plus a one-hot grant. The mux then passes only that channel's data bit to the single output `Q`.

## Interface
Parameters:
- `BURST_LEN`, default 8: maximum accepted beats per grant; legal range 1..255.
- `CNT_W`, default 8: beat counter width; must satisfy `2**CNT_W > BURST_LEN`.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, 4: per-channel request; `req[i]` pairs with mux data input A/B/C/D for i = 0/1/2/3.
- `out_ready`, in, 1: downstream consumer of `Q` accepts a beat this cycle.
- `sel`, out, 2: mux select. `sel[0]` drives mux `a`; `sel[1]` drives mux `b`. Channel i is encoded as `sel = i`.
- `gnt`, out, 4: one-hot grant, equal to `1 << sel` while `sel_valid` is high, otherwise 0.
- `sel_valid`, out, 1: high when `Q` carries a granted channel's bit.
- `beat`, out, 1: equals `sel_valid & out_ready`; marks an accepted beat.

## Operation
- States are IDLE, GRANT and GAP.
- IDLE:
  - `sel_valid` is 0.
  - If any `req` bit is high, pick the first requesting channel at or after `ptr` in increasing order, wrapping 3→0.
  - Load `sel` with that channel, clear the beat counter `cnt` to 0, and go to GRANT.
- GRANT:
  - `sel_valid` is 1 and `sel` is held stable.
  - On each `beat`, `cnt` increments.
  - Leave GRANT for GAP when either of these holds:
    - `beat` occurs with `cnt == BURST_LEN-1`. This is the final beat, and it is counted.
    - `req[sel]` is low. The channel is released early, and no beat is counted in that cycle, even if `out_ready` is high.
  - When `out_ready` is low, hold: `cnt` and `sel` do not change.
- GAP:
  - Lasts exactly one cycle with `sel_valid` = 0. This is a turnaround so the mux select never changes while valid is high.
  - Update `ptr <= sel + 1` (mod 4), then go to IDLE.
- The next arbitration starts in IDLE, one cycle after GAP.
- Requests arriving during GRANT or GAP have no effect until IDLE.
- If several channels request at once, the round-robin pointer alone decides the winner. There is no fixed priority.
- If `req` is all zero in IDLE, stay in IDLE.
- Reset values: state = IDLE, `ptr` = 0, `sel` = 0, `cnt` = 0, `gnt` = 0, `sel_valid` = 0, `beat` = 0.
- Reset mid-burst aborts the grant immediately, with no GAP cycle. The next grant after reset starts the search from channel 0.
- `sel` keeps its last value in IDLE and GAP (don't-care for the mux, but it must not glitch). `gnt` is 0 in those states.

## Timing
- All outputs except `beat` are registered.
- `beat` is combinational from registered `sel_valid` and input `out_ready`.
- Latency from `req` seen in IDLE to `sel_valid` high is 1 cycle.
- Fastest burst cycle with `out_ready` held high and `BURST_LEN = N`:
  - N cycles in GRANT, 1 in GAP, 1 in IDLE.
  - Per-channel throughput is therefore N/(N+2).
- The early-release check uses `req` in the current cycle. `sel_valid` drops on the next edge.
- When `out_ready` is low on the final-beat cycle, the block holds in GRANT until `out_ready` goes high.

## Structure
Shared package `mux_sel_pkg`:
- State enum: `ST_IDLE`, `ST_GRANT`, `ST_GAP`.
- `N_CH = 4` and `SEL_W = 2`.
- A function that converts `sel` to a one-hot value.

Sub-module `rr_pick`:
- Purely combinational.
- Inputs: `req[3:0]` and `ptr[1:0]`.
- Outputs: `found` and `pick[1:0]`.
- Implemented as a rotate, priority-encode, un-rotate.

The top level holds the FSM, `ptr`, `cnt` and the output registers. Expected size is 150–250 lines total.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `req` = 4'b1111.
  - Expected: all outputs 0 during reset.
  - After release: IDLE, then `sel` = 0, `gnt` = 4'b0001.
- **Full burst:** `BURST_LEN` = 4, `req` = 4'b0100, `out_ready` = 1.
  - Expected: `sel` = 2 with `sel_valid` high for exactly 4 cycles, then 1 GAP cycle, then 1 IDLE cycle, then a re-grant to channel 2.
- **Round-robin fairness:** `req` = 4'b1111 held.
  - Expected: grant order 0, 1, 2, 3, 0, and `beat` count per grant equals `BURST_LEN`.
- **Backpressure:** during a grant, `out_ready` = 0 for 3 cycles at `cnt` = 2.
  - Expected: `cnt` frozen at 2 and `sel` stable.
  - Total cycles in GRANT equals `BURST_LEN` + 3.
- **Early release:** channel 1 drops `req` after 2 beats while `out_ready` = 1.
  - Expected: GAP on the next cycle and `ptr` = 2.
  - With `req` = 4'b1001, the next grant goes to channel 3.
- **Reset mid-burst:** assert `rst` at `cnt` = 3.
  - Expected: `sel_valid` = 0 on the next edge, with no GAP.
  - With `req` = 4'b1010 after release, the grant goes to channel 1.
